// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART/ALU host controller and the external ALU:
// controller state encoding and the opcode map the ALU decodes.
package uart_alu_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4
    } state_t;

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
    localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
    localparam logic [OP_W-1:0] OP_AND = 6'b100100;
    localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
    localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
    localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
    localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
    localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/uart_alu_interface.sv
// Pops A, B, opcode from the RX FIFO, hands them to the external ALU, and pushes
// the result byte into the TX FIFO. A stalled partial frame is dropped on timeout.
module uart_alu_interface
    import uart_alu_pkg::*;
#(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned NB_OP   = 6,
    parameter int unsigned TIMEOUT = 1_000_000,
    parameter int unsigned TO_BIT  = 20
) (
    input  logic             i_clk,
    input  logic             reset,
    input  logic             i_rx_empty,
    input  logic [DBIT-1:0]  i_r_data,
    output logic             o_rd_uart,
    input  logic             i_tx_full,
    output logic             o_wr_uart,
    output logic [DBIT-1:0]  o_w_data,
    output logic [DBIT-1:0]  o_data_a,
    output logic [DBIT-1:0]  o_data_b,
    output logic [NB_OP-1:0] o_opcode,
    input  logic [DBIT-1:0]  i_alu_result,
    output logic             o_valid,
    output logic             o_timeout
);

    state_t              r_state;
    state_t              w_next;
    logic [TO_BIT-1:0]   r_to_cnt;
    logic [DBIT-1:0]     r_w_data;
    logic [DBIT-1:0]     r_data_a;
    logic [DBIT-1:0]     r_data_b;
    logic [NB_OP-1:0]    r_opcode;
    logic                w_rx_take;
    logic                w_tx_push;
    logic                w_exec;
    logic                w_to_hit;
    logic                w_to_limit;

    // A zero TIMEOUT never matches, so a partial frame may wait forever.
    assign w_to_limit = (TIMEOUT != 0) && (r_to_cnt == TO_BIT'(TIMEOUT - 1));

    always_comb begin
        w_next    = r_state;
        w_rx_take = 1'b0;
        w_tx_push = 1'b0;
        w_exec    = 1'b0;
        w_to_hit  = 1'b0;
        case (r_state)
            ST_WAIT_A: begin
                if (!i_rx_empty) begin
                    w_rx_take = 1'b1;
                    w_next    = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (!i_rx_empty) begin
                    w_rx_take = 1'b1;
                    w_next    = ST_WAIT_OP;
                end else if (w_to_limit) begin
                    w_to_hit = 1'b1;
                    w_next   = ST_WAIT_A;
                end
            end
            ST_WAIT_OP: begin
                if (!i_rx_empty) begin
                    w_rx_take = 1'b1;
                    w_next    = ST_EXEC;
                end else if (w_to_limit) begin
                    w_to_hit = 1'b1;
                    w_next   = ST_WAIT_A;
                end
            end
            ST_EXEC: begin
                w_exec = 1'b1;
                w_next = ST_SEND;
            end
            ST_SEND: begin
                if (!i_tx_full) begin
                    w_tx_push = 1'b1;
                    w_next    = ST_WAIT_A;
                end
            end
            default: w_next = ST_WAIT_A;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_state  <= ST_WAIT_A;
            r_data_a <= '0;
            r_data_b <= '0;
            r_opcode <= '0;
            r_w_data <= '0;
        end else begin
            r_state <= w_next;
            if (w_rx_take) begin
                case (r_state)
                    ST_WAIT_A:  r_data_a <= i_r_data;
                    ST_WAIT_B:  r_data_b <= i_r_data;
                    ST_WAIT_OP: r_opcode <= i_r_data[NB_OP-1:0];
                    default:    ;
                endcase
            end
            if (w_exec) begin
                r_w_data <= i_alu_result;
            end
        end
    end

    // Counts consecutive empty cycles inside a partial frame.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if ((r_state == ST_WAIT_B || r_state == ST_WAIT_OP) && !w_rx_take && !w_to_hit) begin
            r_to_cnt <= r_to_cnt + TO_BIT'(1);
        end else begin
            r_to_cnt <= '0;
        end
    end

    // FIFO strobes and pulses are suppressed during the reset cycle.
    assign o_rd_uart = w_rx_take & ~reset;
    assign o_wr_uart = w_tx_push & ~reset;
    assign o_valid   = w_exec    & ~reset;
    assign o_timeout = w_to_hit  & ~reset;

    assign o_w_data = r_w_data;
    assign o_data_a = r_data_a;
    assign o_data_b = r_data_b;
    assign o_opcode = r_opcode;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Bench for uart_alu_interface: FIFO and ALU models around the DUT, directed
// scenarios followed by random frames checked against an expected-result queue.
module tb_uart_alu_interface;
    import uart_alu_pkg::*;

    localparam int unsigned DBIT  = 8;
    localparam int unsigned NB_OP = 6;
    localparam int unsigned TMO   = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             i_rx_empty;
    logic [DBIT-1:0]  i_r_data;
    logic             o_rd_uart;
    logic             i_tx_full;
    logic             o_wr_uart;
    logic [DBIT-1:0]  o_w_data;
    logic [DBIT-1:0]  o_data_a;
    logic [DBIT-1:0]  o_data_b;
    logic [NB_OP-1:0] o_opcode;
    logic [DBIT-1:0]  i_alu_result;
    logic             o_valid;
    logic             o_timeout;

    always #5 clk = ~clk;

    uart_alu_interface #(
        .DBIT(DBIT), .NB_OP(NB_OP), .TIMEOUT(TMO), .TO_BIT(20)
    ) dut (
        .i_clk(clk), .reset(reset),
        .i_rx_empty(i_rx_empty), .i_r_data(i_r_data), .o_rd_uart(o_rd_uart),
        .i_tx_full(i_tx_full), .o_wr_uart(o_wr_uart), .o_w_data(o_w_data),
        .o_data_a(o_data_a), .o_data_b(o_data_b), .o_opcode(o_opcode),
        .i_alu_result(i_alu_result), .o_valid(o_valid), .o_timeout(o_timeout)
    );

    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        logic signed [7:0] sa;
        sa = a;
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SRA:  return 8'(sa >>> b);
            OP_SRL:  return a >> b;
            default: return 8'h00;
        endcase
    endfunction

    assign i_alu_result = alu(o_data_a, o_data_b, o_opcode);

    logic [7:0] rxq[$];
    logic [7:0] wr_dat[$];
    logic [7:0] op_at_val[$];
    logic [7:0] expq[$];
    int         rd_cyc[$], wr_cyc[$], val_cyc[$], to_cyc[$];
    int         cyc = 0;
    int         checks = 0;
    int         passes = 0;
    logic       s_rd, s_wr, s_vl, s_to;
    logic [5:0] ops[8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_logs();
        wr_dat.delete(); op_at_val.delete();
        rd_cyc.delete(); wr_cyc.delete(); val_cyc.delete(); to_cyc.delete();
    endtask

    // One clock: present FIFO head at negedge, sample mid-cycle, apply pop/push at posedge.
    task automatic tick();
        logic [7:0] wd;
        i_rx_empty = (rxq.size() == 0);
        i_r_data   = i_rx_empty ? 8'($urandom) : rxq[0];
        #1;
        s_rd = o_rd_uart; s_wr = o_wr_uart; s_vl = o_valid; s_to = o_timeout;
        wd = o_w_data;
        if (s_rd) rd_cyc.push_back(cyc);
        if (s_wr) wr_cyc.push_back(cyc);
        if (s_to) to_cyc.push_back(cyc);
        if (s_vl) begin
            val_cyc.push_back(cyc);
            op_at_val.push_back(8'(o_opcode));
        end
        chk("rd_when_empty", 32'(s_rd & i_rx_empty), 32'd0);
        chk("wr_when_full", 32'(s_wr & i_tx_full), 32'd0);
        @(posedge clk);
        if (s_rd && rxq.size() != 0) void'(rxq.pop_front());
        if (s_wr) wr_dat.push_back(wd);
        cyc++;
        @(negedge clk);
    endtask

    task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        rxq.push_back(a); rxq.push_back(b); rxq.push_back(op);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a, b, a2, b2, opb, opb2, e1, e2;
        int gap;
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};
        reset = 1'b1; i_tx_full = 1'b0; i_rx_empty = 1'b1; i_r_data = '0;
        @(negedge clk);

        // Reset state, with a byte queued and TX free
        rxq.push_back(8'hA5);
        tick(); tick();
        chk("rst_rd", 32'(s_rd), 32'd0);
        chk("rst_wr", 32'(s_wr), 32'd0);
        rxq.delete();
        reset = 1'b0;
        tick();
        chk("rst_w_data", 32'(o_w_data), 32'd0);
        chk("rst_data_a", 32'(o_data_a), 32'd0);
        chk("rst_data_b", 32'(o_data_b), 32'd0);
        chk("rst_opcode", 32'(o_opcode), 32'd0);
        chk("rst_pulses", 32'({s_rd, s_wr, s_vl, s_to}), 32'd0);

        // Single ADD frame, minimum latency
        clear_logs();
        push3(8'h05, 8'h03, 8'h20);
        repeat (8) tick();
        chk("t1_pops", 32'(rd_cyc.size()), 32'd3);
        chk("t1_writes", 32'(wr_dat.size()), 32'd1);
        chk("t1_valids", 32'(val_cyc.size()), 32'd1);
        if (rd_cyc.size() == 3 && wr_dat.size() == 1 && val_cyc.size() == 1) begin
            chk("t1_consecutive", 32'(rd_cyc[2] - rd_cyc[0]), 32'd2);
            chk("t1_valid_lat", 32'(val_cyc[0] - rd_cyc[2]), 32'd1);
            chk("t1_wr_lat", 32'(wr_cyc[0] - rd_cyc[2]), 32'd2);
            chk("t1_result", 32'(wr_dat[0]), 32'h08);
            chk("t1_opcode", 32'(op_at_val[0]), 32'h20);
        end

        // Back-to-back SUB then OR
        clear_logs();
        push3(8'h0F, 8'h01, 8'h22);
        push3(8'hF0, 8'h0F, 8'h25);
        repeat (14) tick();
        chk("t2_writes", 32'(wr_dat.size()), 32'd2);
        if (wr_dat.size() == 2 && rd_cyc.size() == 6) begin
            chk("t2_res0", 32'(wr_dat[0]), 32'h0E);
            chk("t2_res1", 32'(wr_dat[1]), 32'hFF);
            chk("t2_span", 32'(wr_cyc[1] - rd_cyc[0] + 1), 32'd10);
        end

        // TX full for 50 cycles in SEND; a second frame waits in RX
        clear_logs();
        a = 8'($urandom); b = 8'($urandom); opb = {2'($urandom), ops[$urandom_range(0, 7)]};
        a2 = 8'($urandom); b2 = 8'($urandom); opb2 = {2'b00, ops[$urandom_range(0, 7)]};
        e1 = alu(a, b, opb[5:0]); e2 = alu(a2, b2, opb2[5:0]);
        i_tx_full = 1'b1;
        push3(a, b, opb); push3(a2, b2, opb2);
        repeat (4) tick();
        for (int k = 0; k < 50; k++) begin
            tick();
            chk("t3_wdata_stable", 32'(o_w_data), 32'(e1));
        end
        chk("t3_pops_held", 32'(rd_cyc.size()), 32'd3);
        chk("t3_no_write", 32'(wr_dat.size()), 32'd0);
        i_tx_full = 1'b0;
        tick();
        chk("t3_wr_first_free", 32'(s_wr), 32'd1);
        repeat (6) tick();
        chk("t3_writes", 32'(wr_dat.size()), 32'd2);
        if (wr_dat.size() == 2) begin
            chk("t3_res0", 32'(wr_dat[0]), 32'(e1));
            chk("t3_res1", 32'(wr_dat[1]), 32'(e2));
        end

        // Timeout after a lone byte, then a clean frame
        clear_logs();
        rxq.push_back(8'h11);
        repeat (21) tick();
        chk("t4_timeouts", 32'(to_cyc.size()), 32'd1);
        if (to_cyc.size() == 1 && rd_cyc.size() == 1)
            chk("t4_to_delay", 32'(to_cyc[0] - rd_cyc[0]), 32'(TMO));
        chk("t4_stale_a", 32'(o_data_a), 32'h11);
        chk("t4_no_write", 32'(wr_dat.size()), 32'd0);
        push3(8'h02, 8'h02, 8'h20);
        repeat (6) tick();
        chk("t4_writes", 32'(wr_dat.size()), 32'd1);
        if (wr_dat.size() == 1) chk("t4_result", 32'(wr_dat[0]), 32'h04);

        // Byte arriving in the would-be timeout cycle
        clear_logs();
        rxq.push_back(8'h33);
        tick();
        repeat (TMO - 1) tick();
        rxq.push_back(8'h44);
        tick();
        chk("t5_late_pop", 32'(s_rd), 32'd1);
        chk("t5_late_no_to", 32'(s_to), 32'd0);
        rxq.push_back({2'b00, OP_XOR});
        repeat (6) tick();
        chk("t5_timeouts", 32'(to_cyc.size()), 32'd0);
        chk("t5_writes", 32'(wr_dat.size()), 32'd1);
        if (wr_dat.size() == 1) chk("t5_result", 32'(wr_dat[0]), 32'(8'h33 ^ 8'h44));

        // Reset while waiting for the opcode
        clear_logs();
        rxq.push_back(8'hAA); rxq.push_back(8'hBB);
        repeat (2) tick();
        rxq.push_back(8'h20);
        reset = 1'b1;
        tick();
        chk("t6_rst_rd", 32'(s_rd), 32'd0);
        rxq.delete();
        reset = 1'b0;
        chk("t6_regs_zero", 32'({o_data_a, o_data_b, 2'b00, o_opcode, o_w_data}), 32'd0);
        tick();
        chk("t6_pulses_zero", 32'({s_rd, s_wr, s_vl, s_to}), 32'd0);
        push3(8'h07, 8'h09, 8'h20);
        repeat (6) tick();
        chk("t6_writes", 32'(wr_dat.size()), 32'd1);
        if (wr_dat.size() == 1) chk("t6_result", 32'(wr_dat[0]), 32'h10);

        // Reset while blocked in SEND
        clear_logs();
        i_tx_full = 1'b1;
        push3(8'h30, 8'h0C, {2'b00, OP_SUB});
        repeat (5) tick();
        reset = 1'b1; i_tx_full = 1'b0;
        tick();
        chk("t7_rst_wr", 32'(s_wr), 32'd0);
        reset = 1'b0;
        chk("t7_wdata_zero", 32'(o_w_data), 32'd0);
        tick();
        chk("t7_after_wr", 32'(s_wr), 32'd0);
        push3(8'h30, 8'h0C, {2'b11, OP_SUB});
        repeat (6) tick();
        chk("t7_writes", 32'(wr_dat.size()), 32'd1);
        if (wr_dat.size() == 1) chk("t7_result", 32'(wr_dat[0]), 32'h24);

        // Random frames with gaps and TX back-pressure
        clear_logs();
        expq.delete();
        for (int f = 0; f < 30; f++) begin
            a = 8'($urandom); b = 8'($urandom);
            opb = {2'($urandom), ops[$urandom_range(0, 7)]};
            expq.push_back(alu(a, b, opb[5:0]));
            for (int j = 0; j < 3; j++) begin
                rxq.push_back(j == 0 ? a : (j == 1 ? b : opb));
                gap = $urandom_range(0, 4);
                repeat (gap) begin
                    i_tx_full = ($urandom_range(0, 3) == 0);
                    tick();
                end
            end
        end
        for (int k = 0; k < 600 && wr_dat.size() < 30; k++) begin
            i_tx_full = ($urandom_range(0, 3) == 0);
            tick();
        end
        i_tx_full = 1'b0;
        chk("rnd_writes", 32'(wr_dat.size()), 32'd30);
        chk("rnd_timeouts", 32'(to_cyc.size()), 32'd0);
        for (int i = 0; i < 30 && i < wr_dat.size(); i++)
            chk("rnd_result", 32'(wr_dat[i]), 32'(expq[i]));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
